// File: rtl/player_damage_controller.sv
// rtl/player_damage_controller.sv - player HP, hit acceptance, invincibility flash and death latch
// Optional karma drain is built when PLAYER_DAMAGE_KARMA_EN is defined.
module player_damage_controller #(
  parameter int MAX_HP            = 92,
  parameter int HIT_DAMAGE        = 5,
  parameter int INVINCIBLE_FRAMES = 30,
  parameter int FLASH_PERIOD      = 4,
  parameter int KR_MAX            = 40,
  parameter int KR_DRAIN_FRAMES   = 2
) (
  input  logic       clk_player_control,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] player_pos_x,
  input  logic [9:0] player_pos_y,
  input  logic [9:0] player_w,
  input  logic [9:0] player_h,
  input  logic       obj_valid,
  input  logic [9:0] obj_x0,
  input  logic [9:0] obj_y0,
  input  logic [9:0] obj_x1,
  input  logic [9:0] obj_y1,
  input  logic       heal_pulse,
  input  logic [7:0] heal_amount,
  output logic [7:0] hp,
  output logic [5:0] karma,
  output logic       hit_pulse,
  output logic       is_invincible,
  output logic       player_visible,
  output logic       is_dead
);

  localparam logic [7:0] LP_MAX_HP     = 8'(MAX_HP);
  localparam logic [7:0] LP_DAMAGE     = 8'(HIT_DAMAGE);
  localparam logic [7:0] LP_INV_FRAMES = 8'(INVINCIBLE_FRAMES);
  localparam logic [3:0] LP_FLASH      = 4'(FLASH_PERIOD);

  if (MAX_HP > 255 || INVINCIBLE_FRAMES < 1 || INVINCIBLE_FRAMES > 255 ||
      FLASH_PERIOD < 1 || FLASH_PERIOD > 15 || KR_MAX > 63 ||
      KR_DRAIN_FRAMES < 1 || KR_DRAIN_FRAMES > 15) begin : g_bad_cfg
    $error("player_damage_controller: parameter out of range");
  end

  typedef enum logic [1:0] {ST_VULN, ST_INV, ST_DEAD} state_t;

  state_t     r_state;
  logic [7:0] r_hp;
  logic       r_hit_pulse;
  logic       r_is_inv;
  logic       r_visible;
  logic       r_is_dead;
  logic [7:0] r_inv_cnt;
  logic [3:0] r_flash_cnt;

  logic [10:0] w_px_end;
  logic [10:0] w_py_end;
  logic        w_overlap;
  logic        w_hit_now;
  logic        w_vuln_hit;
  logic        w_drain;
  logic        w_enter_dead;
  logic [7:0]  w_hp_pre;
  logic [7:0]  w_hp_dmg;
  logic [7:0]  w_hp_base;
  logic [8:0]  w_heal_sum;
  logic [7:0]  w_hp_next;

  // 11-bit edges so a box near the right/bottom screen edge cannot wrap
  assign w_px_end  = {1'b0, player_pos_x} + {1'b0, player_w};
  assign w_py_end  = {1'b0, player_pos_y} + {1'b0, player_h};
  assign w_overlap = (obj_x1 > obj_x0) && (obj_y1 > obj_y0) &&
                     ({1'b0, obj_x0} < w_px_end) && (obj_x1 > player_pos_x) &&
                     ({1'b0, obj_y0} < w_py_end) && (obj_y1 > player_pos_y);
  assign w_hit_now  = obj_valid && w_overlap;
  assign w_vuln_hit = (r_state == ST_VULN) && w_hit_now;

  // Karma drain lands first, then damage, then heal
  assign w_hp_pre     = r_hp - {7'd0, w_drain};
  assign w_hp_dmg     = (w_hp_pre > LP_DAMAGE) ? (w_hp_pre - LP_DAMAGE) : 8'd0;
  assign w_enter_dead = w_vuln_hit && (w_hp_dmg == 8'd0);
  assign w_hp_base    = w_vuln_hit ? w_hp_dmg : w_hp_pre;
  assign w_heal_sum   = {1'b0, w_hp_base} + {1'b0, heal_amount};
  assign w_hp_next    = !heal_pulse ? w_hp_base :
                        (w_heal_sum > {1'b0, LP_MAX_HP}) ? LP_MAX_HP : w_heal_sum[7:0];

  always_ff @(posedge clk_player_control or posedge reset) begin
    if (reset) begin
      r_state     <= ST_VULN;
      r_hp        <= LP_MAX_HP;
      r_hit_pulse <= 1'b0;
      r_is_inv    <= 1'b0;
      r_visible   <= 1'b1;
      r_is_dead   <= 1'b0;
      r_inv_cnt   <= 8'd0;
      r_flash_cnt <= 4'd0;
    end else begin
      r_hit_pulse <= 1'b0;
      case (r_state)
        ST_VULN: begin
          if (w_hit_now) begin
            r_hit_pulse <= 1'b1;
            r_inv_cnt   <= LP_INV_FRAMES;
            r_flash_cnt <= 4'd0;
            if (w_enter_dead) begin
              r_state   <= ST_DEAD;
              r_hp      <= 8'd0;
              r_is_dead <= 1'b1;
              r_visible <= 1'b1;
              r_is_inv  <= 1'b0;
            end else begin
              r_state   <= ST_INV;
              r_hp      <= w_hp_next;
              r_is_inv  <= 1'b1;
              r_visible <= 1'b0;
            end
          end else begin
            r_hp <= w_hp_next;
          end
        end
        ST_INV: begin
          r_hp <= w_hp_next;
          if (frame_tick) begin
            if (r_inv_cnt <= 8'd1) begin
              r_state     <= ST_VULN;
              r_inv_cnt   <= 8'd0;
              r_flash_cnt <= 4'd0;
              r_is_inv    <= 1'b0;
              r_visible   <= 1'b1;
            end else begin
              r_inv_cnt <= r_inv_cnt - 8'd1;
              if (r_flash_cnt == LP_FLASH - 4'd1) begin
                r_flash_cnt <= 4'd0;
                r_visible   <= ~r_visible;
              end else begin
                r_flash_cnt <= r_flash_cnt + 4'd1;
              end
            end
          end
        end
        default: begin
          r_state <= ST_DEAD;
        end
      endcase
    end
  end

`ifdef PLAYER_DAMAGE_KARMA_EN
  localparam logic [5:0] LP_KR_MAX   = 6'(KR_MAX);
  localparam logic [3:0] LP_KR_DRAIN = 4'(KR_DRAIN_FRAMES);

  logic [5:0] r_karma;
  logic [3:0] r_kr_cnt;
  logic       w_kr_active;
  logic [5:0] w_karma_inc;

  // The drain cadence restarts whenever draining is not allowed
  assign w_kr_active = (r_karma != 6'd0) && (r_state != ST_DEAD) && (r_hp > 8'd1);
  assign w_drain     = w_kr_active && frame_tick && (r_kr_cnt == LP_KR_DRAIN - 4'd1);
  assign w_karma_inc = ((r_state == ST_INV) && w_hit_now && (r_karma != LP_KR_MAX)) ?
                       (r_karma + 6'd1) : r_karma;

  always_ff @(posedge clk_player_control or posedge reset) begin
    if (reset) begin
      r_karma  <= 6'd0;
      r_kr_cnt <= 4'd0;
    end else if (w_enter_dead) begin
      r_karma  <= 6'd0;
      r_kr_cnt <= 4'd0;
    end else begin
      r_karma <= w_karma_inc - {5'd0, w_drain};
      if (!w_kr_active) begin
        r_kr_cnt <= 4'd0;
      end else if (frame_tick) begin
        r_kr_cnt <= w_drain ? 4'd0 : (r_kr_cnt + 4'd1);
      end
    end
  end

  assign karma = r_karma;
`else
  assign w_drain = 1'b0;
  assign karma   = 6'd0;
`endif

  assign hp             = r_hp;
  assign hit_pulse      = r_hit_pulse;
  assign is_invincible  = r_is_inv;
  assign player_visible = r_visible;
  assign is_dead        = r_is_dead;

endmodule

// File: tb/tb_player_damage_controller.sv
// tb/tb_player_damage_controller.sv - scoreboard bench for player_damage_controller
module tb_player_damage_controller;

  localparam int MAX_HP = 92;
  localparam int DMG    = 5;
  localparam int INV    = 30;
  localparam int FP     = 4;
  localparam int KRM    = 40;
  localparam int KRD    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       obj_valid = 1'b0;
  logic       heal_pulse = 1'b0;
  logic [9:0] px = '0, py = '0, pw = '0, ph = '0;
  logic [9:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [7:0] heal_amount = '0;
  logic [7:0] hp;
  logic [5:0] karma;
  logic       hit_pulse, is_inv, vis, dead;

  always #5 clk = ~clk;

  player_damage_controller #(
    .MAX_HP(MAX_HP), .HIT_DAMAGE(DMG), .INVINCIBLE_FRAMES(INV),
    .FLASH_PERIOD(FP), .KR_MAX(KRM), .KR_DRAIN_FRAMES(KRD)
  ) dut (
    .clk_player_control(clk), .reset(rst), .frame_tick(frame_tick),
    .player_pos_x(px), .player_pos_y(py), .player_w(pw), .player_h(ph),
    .obj_valid(obj_valid), .obj_x0(x0), .obj_y0(y0), .obj_x1(x1), .obj_y1(y1),
    .heal_pulse(heal_pulse), .heal_amount(heal_amount),
    .hp(hp), .karma(karma), .hit_pulse(hit_pulse), .is_invincible(is_inv),
    .player_visible(vis), .is_dead(dead)
  );

  typedef struct {
    int    hp;
    int    karma;
    bit    pulse;
    bit    inv;
    bit    vis;
    bit    dead;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference state: hp, karma, frames elapsed since the last accepted hit
  int m_hp, m_karma, m_ticks, m_kcnt;
  bit m_inv, m_dead;
  int n_px, n_py, n_pw, n_ph;

  task automatic chk(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, want, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int clamp10(input int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  function automatic bit ref_overlap(input int ax0, input int ay0, input int ax1, input int ay1);
    if (ax1 <= ax0 || ay1 <= ay0) return 1'b0;
    return (ax0 < n_px + n_pw) && (ax1 > n_px) && (ay0 < n_py + n_ph) && (ay1 > n_py);
  endfunction

  task automatic model_reset();
    m_hp = MAX_HP; m_karma = 0; m_ticks = 0; m_kcnt = 0; m_inv = 1'b0; m_dead = 1'b0;
  endtask

  task automatic drive(input bit tick, input bit ov, input int ax0, input int ay0,
                       input int ax1, input int ay1, input bit heal, input int amt,
                       input string tag);
    exp_t e;
    bit   hit;
    bit   drain;
    int   pre;
    @(negedge clk);
    px = 10'(n_px); py = 10'(n_py); pw = 10'(n_pw); ph = 10'(n_ph);
    frame_tick = tick; obj_valid = ov;
    x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
    heal_pulse = heal; heal_amount = 8'(amt);
    hit   = ov && ref_overlap(ax0, ay0, ax1, ay1);
    drain = 1'b0;
    e.pulse = 1'b0;
`ifdef PLAYER_DAMAGE_KARMA_EN
    if (m_karma > 0 && !m_dead && m_hp > 1) begin
      if (tick) begin
        m_kcnt++;
        if (m_kcnt == KRD) begin drain = 1'b1; m_kcnt = 0; end
      end
    end else begin
      m_kcnt = 0;
    end
    if (m_inv && !m_dead && hit) m_karma = imin(KRM, m_karma + 1);
    if (drain) m_karma--;
`endif
    pre = m_hp - int'(drain);
    if (!m_dead) begin
      if (!m_inv) begin
        if (hit) begin
          pre = (pre > DMG) ? pre - DMG : 0;
          e.pulse = 1'b1;
          if (pre == 0) begin
            m_dead = 1'b1; m_karma = 0; m_kcnt = 0;
          end else begin
            m_inv = 1'b1; m_ticks = 0;
          end
        end
      end else if (tick) begin
        m_ticks++;
        if (m_ticks >= INV) m_inv = 1'b0;
      end
      if (m_dead) m_hp = 0;
      else m_hp = heal ? imin(MAX_HP, pre + amt) : pre;
    end
    e.hp    = m_hp;
    e.karma = m_karma;
    e.dead  = m_dead;
    e.inv   = m_inv && !m_dead;
    e.vis   = m_dead ? 1'b1 : m_inv ? (((m_ticks / FP) % 2) == 1) : 1'b1;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    frame_tick = 1'b0; obj_valid = 1'b0; heal_pulse = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk({tag, ".rst_hp"}, int'(hp), MAX_HP);
    chk({tag, ".rst_karma"}, int'(karma), 0);
    chk({tag, ".rst_pulse"}, int'(hit_pulse), 0);
    chk({tag, ".rst_inv"}, int'(is_inv), 0);
    chk({tag, ".rst_vis"}, int'(vis), 1);
    chk({tag, ".rst_dead"}, int'(dead), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic hit_std(input bit heal, input int amt, input string tag);
    drive(1'b0, 1'b1, 110, 110, 130, 130, heal, amt, tag);
  endtask

  task automatic ticks(input int n, input bit ov, input string tag);
    for (int i = 0; i < n; i++) drive(1'b1, ov, 110, 110, 130, 130, 1'b0, 0, tag);
  endtask

  // monitor: every clock the DUT presents a fresh registered response
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".hp"}, int'(hp), e.hp);
        chk({e.tag, ".karma"}, int'(karma), e.karma);
        chk({e.tag, ".hit_pulse"}, int'(hit_pulse), int'(e.pulse));
        chk({e.tag, ".is_invincible"}, int'(is_inv), int'(e.inv));
        chk({e.tag, ".player_visible"}, int'(vis), int'(e.vis));
        chk({e.tag, ".is_dead"}, int'(dead), int'(e.dead));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ax0, ay0, ax1, ay1;
    n_px = 100; n_py = 100; n_pw = 16; n_ph = 16;
    model_reset();
    do_reset("init");
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0, "idle");

    hit_std(1'b0, 0, "first_hit");
    ticks(INV, 1'b1, "inv_window");
    hit_std(1'b0, 0, "second_hit");

    do_reset("edges");
    drive(1'b0, 1'b1, 116, 100, 140, 120, 1'b0, 0, "touch_right");
    drive(1'b0, 1'b1, 84, 100, 100, 120, 1'b0, 0, "touch_left");
    drive(1'b0, 1'b1, 100, 116, 116, 130, 1'b0, 0, "touch_bottom");
    drive(1'b0, 1'b1, 110, 110, 110, 130, 1'b0, 0, "zero_width");
    drive(1'b0, 1'b1, 110, 120, 130, 105, 1'b0, 0, "neg_height");

    hit_std(1'b0, 0, "heal_setup");
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3, "heal_to_90");
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 10, "heal_sat");

    do_reset("death");
    for (int h = 0; h < 19; h++) begin
      hit_std(1'b0, 0, "death_hit");
      if (h < 18) ticks(INV, 1'b0, "death_wait");
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 110, 110, 130, 130, 1'b1, 50, "dead_hold");
    do_reset("dead_reset");

    for (int h = 0; h < 18; h++) begin
      hit_std(1'b0, 0, "to_hp2");
      ticks(INV, 1'b0, "to_hp2_wait");
    end
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3, "heal_to_5");
    hit_std(1'b1, 20, "hit_heal_dead");
    do_reset("post_hit_heal");

`ifdef PLAYER_DAMAGE_KARMA_EN
    hit_std(1'b0, 0, "kr_hit");
    for (int i = 0; i < 3; i++) hit_std(1'b0, 0, "kr_ignored");
    ticks(6, 1'b0, "kr_drain");
    do_reset("kr_done");
`endif

    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        if ((i / 200) % 4 == 3) begin
          n_px = $urandom_range(990, 1023); n_pw = $urandom_range(20, 1023);
          n_py = $urandom_range(990, 1023); n_ph = $urandom_range(20, 1023);
        end else begin
          n_px = $urandom_range(0, 1023); n_pw = $urandom_range(1, 40);
          n_py = $urandom_range(0, 1023); n_ph = $urandom_range(1, 40);
        end
      end
      if ($urandom_range(0, 299) == 0 || (m_dead && $urandom_range(0, 7) == 0))
        do_reset("rand_reset");
      ax0 = clamp10(n_px + int'($urandom_range(0, 60)) - 30);
      ax1 = clamp10(ax0 + int'($urandom_range(0, 40)) - 4);
      ay0 = clamp10(n_py + int'($urandom_range(0, 60)) - 30);
      ay1 = clamp10(ay0 + int'($urandom_range(0, 40)) - 4);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, ax0, ay0, ax1, ay1,
            $urandom_range(0, 15) == 0, int'($urandom_range(0, 255)), "random");
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/player_damage_controller.md
Name: player_damage_controller

Overview:
- Downstream consumer of the player position controller: takes the registered player box (player_pos_x/y, player_w/h) and tests it against attack-object bounding boxes streamed one per cycle by the attack renderer.
- Owns player HP, post-hit invincibility frames, sprite flash and death latch.
- Feeds the HUD and the game-state controller.

Parameters:
- MAX_HP, 92, HP at reset and heal ceiling (max 255)
- HIT_DAMAGE, 5, HP removed per accepted hit
- INVINCIBLE_FRAMES, 30, frame_tick count of invincibility after a hit (1..255)
- FLASH_PERIOD, 4, frame_ticks per toggle of player_visible while invincible (1..15)
- KR_MAX, 40, karma ceiling (KARMA_EN only, max 63)
- KR_DRAIN_FRAMES, 2, frame_ticks per 1 HP karma drain (KARMA_EN only, 1..15)

Ports:
- clk_player_control  in  1  block clock, same domain as the position controller
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- player_pos_x  in  10  player box left edge, pixels
- player_pos_y  in  10  player box top edge, pixels
- player_w  in  10  player box width
- player_h  in  10  player box height
- obj_valid  in  1  obj_* box valid this cycle
- obj_x0 / obj_y0 / obj_x1 / obj_y1  in  10 each  attack box; x1/y1 exclusive
- heal_pulse  in  1  one-cycle heal request
- heal_amount  in  8  HP added on heal_pulse
- hp  out  8  current HP
- karma  out  6  karma accumulator; 0 when KARMA_EN undefined
- hit_pulse  out  1  one-cycle pulse on an accepted hit
- is_invincible  out  1  high while INVINCIBLE
- player_visible  out  1  sprite enable for the renderer
- is_dead  out  1  latched death flag

Behaviour:
- Reset (async, any time): hp=MAX_HP, karma=0, hit_pulse=0, is_invincible=0, player_visible=1, is_dead=0, state=VULNERABLE, counters=0. Reset mid-invincibility or while DEAD returns fully to these values.
- Overlap, combinational in 11-bit unsigned to avoid wrap: (obj_x0 < px+pw) && (obj_x1 > px) && (obj_y0 < py+ph) && (obj_y1 > py). Touching edges do not count. obj boxes with x1<=x0 or y1<=y0 never hit.
- hit_now = obj_valid && overlap. At most one hit is accepted per cycle, regardless of how many objects overlap.
- Latency: object at edge N produces hp, hit_pulse and state updates registered at edge N+1.
- State VULNERABLE, on hit_now:
  - hp <= sat(hp - HIT_DAMAGE) at 0; hit_pulse=1; invincibility counter <= INVINCIBLE_FRAMES; flash counter=0; player_visible<=0.
  - If the new hp is 0, go to DEAD; otherwise go to INVINCIBLE.
- State INVINCIBLE:
  - Hits are ignored (no hp change, no hit_pulse).
  - Each frame_tick decrements the invincibility counter and advances the flash counter. player_visible toggles each time the flash counter reaches FLASH_PERIOD; the flash counter then clears.
  - The counter-reaching-0 tick goes to VULNERABLE with player_visible=1. A hit in that same cycle is still ignored.
- State DEAD: hp=0, is_dead=1, player_visible=1, hits and heals ignored. Exit only by reset.
- Heal: heal_pulse in VULNERABLE or INVINCIBLE sets hp <= min(MAX_HP, hp + heal_amount), computed in 9 bits.
  - Heal and hit in the same cycle: apply damage first, then heal.
  - If the damaged value is 0, enter DEAD and drop the heal.
- frame_tick and obj_valid are independent and may coincide.

Optional Feature:
- Macro: PLAYER_DAMAGE_KARMA_EN.
- Defined:
  - A hit ignored in INVINCIBLE adds 1 to karma, saturating at KR_MAX.
  - While karma>0, not DEAD and hp>1, every KR_DRAIN_FRAMES frame_ticks: hp-=1 and karma-=1.
  - Karma never reduces hp below 1. Karma clears to 0 on entering DEAD.
  - A heal does not change karma.
- Undefined: no karma logic is synthesized, karma is tied to 0, and ignored hits have no effect.

Test Plan:
- Player (100,100,16,16), obj (110,110,130,130) valid one cycle -> next edge hp=87, hit_pulse=1 for one cycle, is_invincible=1, player_visible=0.
- Obj (116,100,140,120) touching the right edge -> no hit, hp stays 92. Obj x1=x0 -> no hit.
- After a hit, continuous overlap and 30 frame_ticks -> hp stays 87; player_visible toggles on ticks 4, 8, 12, ...; on tick 30, is_invincible=0 and player_visible=1; the next overlapping cycle gives hp=82.
- Hits repeated after each invincibility window, 19 in total -> hp=0 and is_dead=1 at the 19th hit; later hits and heal_pulse with heal_amount=50 -> hp stays 0; assert reset mid-cycle -> hp=92 and is_dead=0 asynchronously.
- hp=90 with heal_amount=10 -> hp=92 (saturates). hp=5 with a hit plus heal_pulse(20) in the same cycle -> DEAD, hp=0.
- KARMA_EN: 3 ignored hits during invincibility -> karma=3; after 6 frame_ticks, hp has dropped by 3 and karma=0. At hp=2 with karma=5 -> hp floors at 1.
